// File: rtl/timer_pkg.sv
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared definitions for the memory-mapped down-counter timer:
//                register offsets, FSM state encodings, mode codes and CTRL
//                bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  // Register offsets as decoded from Addr[3:2]
  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_PRESET = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;

  // Counter FSM state encodings
  localparam logic [1:0] TIMER_IDLE = 2'd0;
  localparam logic [1:0] TIMER_LOAD = 2'd1;
  localparam logic [1:0] TIMER_CNT  = 2'd2;
  localparam logic [1:0] TIMER_INT  = 2'd3;

  // CTRL.Mode codes; codes 2 and 3 fall back to one-shot behaviour
  localparam logic [1:0] TIMER_MODE_ONESHOT = 2'd0;
  localparam logic [1:0] TIMER_MODE_AUTO    = 2'd1;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

endpackage

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
//  Module      : timer_counter
//  Description : Programmable 32-bit down-counter peripheral with CTRL, PRESET
//                and COUNT registers and a maskable interrupt request.
//                Build option TIMER_AUTORELOAD_EN enables Mode 1 (auto-reload
//                with a one-cycle IRQ pulse); without it every mode is
//                one-shot with a level IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_counter
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_enable;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic [1:0]  w_sel;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_autoreload;
  logic        w_count_gt1;
  logic        w_load;
  logic        w_dec;
  logic        w_expire;
  logic        w_stop_en;
  logic        w_pulse_end;
  logic        w_unused_addr;

  assign w_sel         = Addr[3:2];
  assign w_unused_addr = ^{Addr[31:4], Addr[1:0]};
  assign w_wr_ctrl     = WE && (w_sel == TIMER_CTRL);
  assign w_wr_preset   = WE && (w_sel == TIMER_PRESET);
  assign w_count_gt1   = (r_count > 32'd1);

`ifdef TIMER_AUTORELOAD_EN
  assign w_autoreload = (r_mode == TIMER_MODE_AUTO);
`else
  assign w_autoreload = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= TIMER_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decision from pre-edge register values
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TIMER_IDLE: if (r_enable) w_state_next = TIMER_LOAD;
      TIMER_LOAD: w_state_next = TIMER_CNT;
      TIMER_CNT: begin
        if (!r_enable)        w_state_next = TIMER_IDLE;
        else if (!w_count_gt1) w_state_next = TIMER_INT;
      end
      default:    w_state_next = TIMER_IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_expire    = 1'b0;
    w_stop_en   = 1'b0;
    w_pulse_end = 1'b0;
    case (r_state)
      TIMER_LOAD: w_load = 1'b1;
      TIMER_CNT: begin
        if (r_enable) begin
          if (w_count_gt1) w_dec    = 1'b1;
          else             w_expire = 1'b1;
        end
      end
      TIMER_INT: begin
        // Auto-reload keeps Enable so IDLE immediately reloads; the flag
        // is dropped on the way out to make the IRQ a single-cycle pulse.
        if (w_autoreload) w_pulse_end = 1'b1;
        else              w_stop_en   = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file, counter and interrupt flag; CPU writes override the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable   <= 1'b0;
      r_mode     <= TIMER_MODE_ONESHOT;
      r_im       <= 1'b0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= Din[CTRL_EN_BIT];
        r_mode   <= Din[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_im     <= Din[CTRL_IM_BIT];
      end else if (w_stop_en) begin
        r_enable <= 1'b0;
      end

      if (w_wr_preset) r_preset <= Din;

      if (w_load)        r_count <= r_preset;
      else if (w_dec)    r_count <= r_count - 32'd1;
      else if (w_expire) r_count <= 32'd0;

      // Setting the flag beats a same-edge clear from a CPU write
      if (w_expire)
        r_irq_flag <= 1'b1;
      else if (w_wr_ctrl || w_wr_preset || w_pulse_end)
        r_irq_flag <= 1'b0;
    end
  end

  // Combinational read mux
  always_comb begin
    Dout = 32'd0;
    case (w_sel)
      TIMER_CTRL:   Dout = {28'd0, r_im, r_mode, r_enable};
      TIMER_PRESET: Dout = r_preset;
      TIMER_COUNT:  Dout = r_count;
      default:      Dout = 32'd0;
    endcase
  end

  // IRQ is a gate of two flops, so it never glitches on bus activity
  assign IRQ = r_im & r_irq_flag;

endmodule

`default_nettype wire

// File: tb/tb_timer_counter.sv
// ============================================================================
//  Module      : tb_timer_counter
//  Description : Self-checking bench for timer_counter: directed timing
//                scenarios plus randomized bus traffic against a behavioural
//                model of the register/countdown rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] Addr;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TIMER_AUTORELOAD_EN
  localparam bit c_autoreload = 1'b1;
`else
  localparam bit c_autoreload = 1'b0;
`endif

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #10 clk = ~clk;

  // Behavioural model: the timer's life-cycle phases
  typedef enum int {PH_IDLE, PH_ARMED, PH_RUNNING, PH_EXPIRED} phase_t;
  phase_t      m_ph     = PH_IDLE;
  bit          m_en     = 1'b0;
  bit [1:0]    m_mode   = 2'd0;
  bit          m_im     = 1'b0;
  bit [31:0]   m_preset = 32'd0;
  bit [31:0]   m_count  = 32'd0;
  bit          m_flag   = 1'b0;

  function automatic bit [31:0] model_read(input int sel);
    case (sel)
      0:       return {28'd0, m_im, m_mode, m_en};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step(input bit rst, input bit we,
                                     input logic [31:0] addr,
                                     input logic [31:0] din);
    phase_t   ph   = m_ph;
    bit       en   = m_en;
    bit [31:0] cnt = m_count;
    bit       set_f = 1'b0;
    bit       clr_f = 1'b0;
    bit       repeat_mode = c_autoreload && (m_mode == 2'd1);
    if (rst) begin
      m_ph = PH_IDLE; m_en = 0; m_mode = 0; m_im = 0;
      m_preset = 0; m_count = 0; m_flag = 0;
      return;
    end
    if (m_ph == PH_IDLE && m_en) ph = PH_ARMED;
    if (m_ph == PH_ARMED) begin cnt = m_preset; ph = PH_RUNNING; end
    if (m_ph == PH_RUNNING) begin
      if (!m_en) ph = PH_IDLE;
      else if (m_count >= 2) cnt = m_count - 1;
      else begin cnt = 0; set_f = 1; ph = PH_EXPIRED; end
    end
    if (m_ph == PH_EXPIRED) begin
      ph = PH_IDLE;
      if (repeat_mode) clr_f = 1; else en = 0;
    end
    if (we && addr[3:2] == 2'd0) begin
      en = din[0]; m_mode = din[2:1]; m_im = din[3]; clr_f = 1;
    end
    if (we && addr[3:2] == 2'd1) begin
      m_preset = din; clr_f = 1;
    end
    if (set_f)      m_flag = 1;
    else if (clr_f) m_flag = 0;
    m_ph = ph; m_en = en; m_count = cnt;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle, then read back all four registers and IRQ against the model
  task automatic tick(input bit rst, input bit we, input logic [31:0] addr,
                      input logic [31:0] din);
    string tags[4] = '{"rd_ctrl", "rd_preset", "rd_count", "rd_unused"};
    @(negedge clk);
    reset = rst; WE = we; Addr = addr; Din = din;
    @(posedge clk);
    model_step(rst, we, addr, din);
    #1;
    reset = 1'b0; WE = 1'b0;
    for (int a = 0; a < 4; a++) begin
      Addr = 32'(a) << 2;
      #1;
      check(tags[a], Dout, model_read(a));
    end
    check("irq", {31'd0, IRQ}, {31'd0, m_im & m_flag});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Edges counted from the enabling write (edge 0) until IRQ is seen high
  task automatic wait_irq(input int start, output int edges);
    edges = start;
    while (IRQ !== 1'b1 && edges < 60) begin
      idle(1);
      edges++;
    end
  endtask

  task automatic peek(input string tag, input logic [31:0] addr,
                      input logic [31:0] exp);
    Addr = addr;
    #1;
    check(tag, Dout, exp);
  endtask

  int k;
  int highs;
  logic [31:0] ra;
  logic [31:0] rd;
  bit rr;
  bit rw;

  initial begin
    reset = 1'b1; WE = 1'b0; Addr = 32'h0; Din = 32'h0;
    tick(1'b1, 1'b0, 32'h0, 32'h0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);

    // One-shot: PRESET=5 -> IRQ 7 edges after the enabling write, level held
    tick(1'b0, 1'b1, 32'h4, 32'd5);
    tick(1'b0, 1'b1, 32'h0, 32'h9);
    wait_irq(0, k);
    check("oneshot_latency", k, 32'd7);
    idle(3);
    check("oneshot_hold", {31'd0, IRQ}, 32'd1);
    peek("oneshot_ctrl", 32'h0, 32'h8);
    tick(1'b0, 1'b1, 32'h0, 32'h8);
    check("oneshot_clear", {31'd0, IRQ}, 32'd0);

    // Reset in the middle of a long count
    tick(1'b0, 1'b1, 32'h4, 32'd100);
    tick(1'b0, 1'b1, 32'h0, 32'h9);
    k = 0;
    while (m_count != 32'd40 && k < 200) begin idle(1); k++; end
    check("reach_count40", k < 200, 32'd1);
    tick(1'b1, 1'b0, 32'h0, 32'h0);
    peek("rst_mid_count", 32'h8, 32'd0);
    peek("rst_mid_ctrl", 32'h0, 32'd0);
    check("rst_mid_irq", {31'd0, IRQ}, 32'd0);

    // Mode 1, PRESET=3: pulses every 6 edges (one-shot level otherwise)
    tick(1'b0, 1'b1, 32'h4, 32'd3);
    tick(1'b0, 1'b1, 32'h0, 32'hB);
    highs = 0;
    for (int i = 0; i < 18; i++) begin
      idle(1);
      if (IRQ === 1'b1) highs++;
    end
    check("mode1_highs", highs, c_autoreload ? 32'd3 : 32'd14);
    tick(1'b0, 1'b1, 32'h0, 32'h0);
    idle(3);

    // Masked interrupt, then a CTRL write clears the pending flag
    tick(1'b0, 1'b1, 32'h4, 32'd2);
    tick(1'b0, 1'b1, 32'h0, 32'h1);
    idle(8);
    check("im0_irq", {31'd0, IRQ}, 32'd0);
    tick(1'b0, 1'b1, 32'h0, 32'h9);
    check("im0_unmask", {31'd0, IRQ}, 32'd0);
    tick(1'b0, 1'b1, 32'h0, 32'h0);
    idle(3);

    // Read-only and unused offsets, reserved CTRL bits
    tick(1'b0, 1'b1, 32'h8, 32'hFFFF);
    tick(1'b0, 1'b1, 32'hC, 32'hFFFF);
    tick(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
    peek("ctrl_reserved", 32'h0, 32'hF);
    peek("unused_read", 32'hC, 32'h0);
    tick(1'b0, 1'b1, 32'h0, 32'h0);
    idle(3);

    // PRESET=0 acts like 1
    tick(1'b0, 1'b1, 32'h4, 32'd0);
    tick(1'b0, 1'b1, 32'h0, 32'h9);
    wait_irq(0, k);
    check("preset0_latency", k, 32'd3);
    tick(1'b0, 1'b1, 32'h0, 32'h0);
    idle(3);

    // PRESET rewrite mid-count leaves the current run alone
    tick(1'b0, 1'b1, 32'h4, 32'd6);
    tick(1'b0, 1'b1, 32'h0, 32'h9);
    idle(3);
    tick(1'b0, 1'b1, 32'h4, 32'd2);
    wait_irq(4, k);
    check("preset_rewrite_latency", k, 32'd8);
    tick(1'b0, 1'b1, 32'h0, 32'h0);
    idle(3);

    // Randomized bus traffic
    for (int i = 0; i < 1500; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      rw = ($urandom_range(0, 5) == 0);
      ra = $urandom;
      rd = (ra[3:2] == 2'd1) ? 32'($urandom_range(0, 9)) : $urandom;
      tick(rr, rw, ra, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
